// File: rtl/axi_rr_req_arbiter.sv
`default_nettype none
// =============================================================================
// axi_rr_req_arbiter : round-robin sharing of one AXI master port among NumReq
//                      req/gnt/rvalid requesters; single beat, one outstanding.
// Revision 1.0
// =============================================================================

package ariane_axi;
   localparam int unsigned ID_WIDTH   = 4;
   localparam int unsigned ADDR_WIDTH = 64;
   localparam int unsigned DATA_WIDTH = 64;
   localparam int unsigned USER_WIDTH = 1;

   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [ADDR_WIDTH-1:0] addr;
      logic [7:0]            len;
      logic [2:0]            size;
      logic [1:0]            burst;
      logic                  lock;
      logic [3:0]            cache;
      logic [2:0]            prot;
      logic [3:0]            qos;
      logic [3:0]            region;
      logic [5:0]            atop;
      logic [USER_WIDTH-1:0] user;
   } aw_chan_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]   data;
      logic [DATA_WIDTH/8-1:0] strb;
      logic                    last;
      logic [USER_WIDTH-1:0]   user;
   } w_chan_t;

   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [1:0]            resp;
      logic [USER_WIDTH-1:0] user;
   } b_chan_t;

   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [ADDR_WIDTH-1:0] addr;
      logic [7:0]            len;
      logic [2:0]            size;
      logic [1:0]            burst;
      logic                  lock;
      logic [3:0]            cache;
      logic [2:0]            prot;
      logic [3:0]            qos;
      logic [3:0]            region;
      logic [USER_WIDTH-1:0] user;
   } ar_chan_t;

   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [DATA_WIDTH-1:0] data;
      logic [1:0]            resp;
      logic                  last;
      logic [USER_WIDTH-1:0] user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } resp_t;
endpackage

module axi_rr_req_arbiter #(
   parameter int unsigned NumReq     = 4,
   parameter int unsigned AddrWidth  = 64,
   parameter int unsigned DataWidth  = 64,
   parameter int unsigned AxiIdWidth = 4,
   parameter type         req_t      = ariane_axi::req_t,
   parameter type         resp_t     = ariane_axi::resp_t
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NumReq-1:0]                    req_i,
   input  logic [NumReq-1:0]                    we_i,
   input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
   input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
   input  logic [NumReq-1:0][DataWidth/8-1:0]   be_i,
   output logic [NumReq-1:0]                    gnt_o,
   output logic [NumReq-1:0]                    rvalid_o,
   output logic [DataWidth-1:0]                 rdata_o,
   output logic                                 err_o,
   output req_t                                 axi_req_o,
   input  resp_t                                axi_resp_i
);

   localparam int unsigned IDX_W    = $clog2(NumReq);
   localparam logic [2:0]  AXI_SIZE = 3'($clog2(DataWidth/8));

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AWW  = 3'd3,
      ST_B    = 3'd4
   } state_e;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [IDX_W-1:0]       win_q, win_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic [DataWidth-1:0]   wdata_q, wdata_d;
   logic [DataWidth/8-1:0] be_q, be_d;
   logic                   aw_done_q, aw_done_d;
   logic                   w_done_q, w_done_d;
   logic [NumReq-1:0]      rvalid_q, rvalid_d;
   logic [DataWidth-1:0]   rdata_q, rdata_d;
   logic                   err_q, err_d;

   logic [IDX_W-1:0]       arb_idx;
   logic                   arb_found;
   logic                   unused_resp_bits;

   // Scan ptr+1 .. ptr (wrapping); first set request wins.
   always_comb begin : arb_scan
      logic [IDX_W-1:0] cand;
      cand      = '0;
      arb_idx   = '0;
      arb_found = 1'b0;
      for (int unsigned i = 1; i <= NumReq; i++) begin
         cand = IDX_W'((32'(ptr_q) + i) % NumReq);
         if (!arb_found && req_i[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   always_comb begin : fsm_next
      state_d   = state_q;
      ptr_d     = ptr_q;
      win_d     = win_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rvalid_d  = '0;
      rdata_d   = rdata_q;
      err_d     = err_q;
      gnt_o     = '0;

      unique case (state_q)
         ST_IDLE: begin
            // The cycle rvalid_o pulses is spent in IDLE without granting.
            if (arb_found && !(|rvalid_q) && rst_ni) begin
               gnt_o[arb_idx] = 1'b1;
               win_d          = arb_idx;
               ptr_d          = arb_idx;
               addr_d         = addr_i[arb_idx];
               wdata_d        = wdata_i[arb_idx];
               be_d           = be_i[arb_idx];
               state_d        = we_i[arb_idx] ? ST_AWW : ST_AR;
            end
         end
         ST_AR: begin
            if (axi_resp_i.ar_ready) state_d = ST_R;
         end
         ST_R: begin
            if (axi_resp_i.r_valid) begin
               rvalid_d[win_q] = 1'b1;
               rdata_d         = axi_resp_i.r.data;
               err_d           = axi_resp_i.r.resp[1];
               state_d         = ST_IDLE;
            end
         end
         ST_AWW: begin
            aw_done_d = aw_done_q | axi_resp_i.aw_ready;
            w_done_d  = w_done_q  | axi_resp_i.w_ready;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = ST_B;
            end
         end
         ST_B: begin
            if (axi_resp_i.b_valid) begin
               rvalid_d[win_q] = 1'b1;
               err_d           = axi_resp_i.b.resp[1];
               state_d         = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin : axi_drive
      axi_req_o            = '0;
      axi_req_o.ar_valid   = (state_q == ST_AR);
      axi_req_o.r_ready    = (state_q == ST_R);
      axi_req_o.aw_valid   = (state_q == ST_AWW) && !aw_done_q;
      axi_req_o.w_valid    = (state_q == ST_AWW) && !w_done_q;
      axi_req_o.b_ready    = (state_q == ST_B);

      axi_req_o.ar.id      = AxiIdWidth'(win_q);
      axi_req_o.ar.addr    = addr_q;
      axi_req_o.ar.size    = AXI_SIZE;
      axi_req_o.ar.burst   = 2'b01;
      axi_req_o.ar.cache   = 4'b0010;

      axi_req_o.aw.id      = AxiIdWidth'(win_q);
      axi_req_o.aw.addr    = addr_q;
      axi_req_o.aw.size    = AXI_SIZE;
      axi_req_o.aw.burst   = 2'b01;
      axi_req_o.aw.cache   = 4'b0010;

      axi_req_o.w.data     = wdata_q;
      axi_req_o.w.strb     = be_q;
      axi_req_o.w.last     = 1'b1;
   end

   // Response IDs, last and user are deliberately ignored.
   assign unused_resp_bits = ^{axi_resp_i.r.id, axi_resp_i.r.last, axi_resp_i.r.user,
                               axi_resp_i.r.resp[0], axi_resp_i.b.id, axi_resp_i.b.user,
                               axi_resp_i.b.resp[0]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         ptr_q     <= IDX_W'(NumReq - 1);
         win_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rvalid_q  <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         win_q     <= win_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_rr_req_arbiter.sv
`default_nettype none
// =============================================================================
// tb_axi_rr_req_arbiter : table-driven + scoreboard bench for axi_rr_req_arbiter
// Revision 1.0
// =============================================================================
module tb_axi_rr_req_arbiter;
   localparam int N = 4;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [N-1:0]         req, we, gnt, rvalid;
   logic [N-1:0][63:0]   addr, wdata;
   logic [N-1:0][7:0]    be;
   logic [63:0]          rdata;
   logic                 err;
   ariane_axi::req_t     axi_req;
   ariane_axi::resp_t    axi_resp;

   always #5 clk = ~clk;

   axi_rr_req_arbiter #(.NumReq(N), .AddrWidth(64), .DataWidth(64), .AxiIdWidth(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
      .err_o(err), .axi_req_o(axi_req), .axi_resp_i(axi_resp)
   );

   typedef struct { int win; bit we; logic [63:0] addr; logic [63:0] data; logic [7:0] be; bit err; } exp_t;
   typedef struct { logic [3:0] req; logic [3:0] we; int exp_win; logic [63:0] base; } vec_t;

   exp_t        sb[$];
   int          n_checks = 0, n_pass = 0;

   // requester model
   logic [N-1:0] p_req, p_we;
   logic [63:0]  p_addr[N], p_wdata[N];
   logic [7:0]   p_be[N];
   int           m_ptr, last_win, n_grants;
   bit           busy, rand_on;

   // slave model
   bit           rnd_dly, ovr_en, rd_pend, rd_err, wr_err, aw_got, w_got;
   logic [63:0]  ovr_data, rd_data;
   int           ar_dly, aw_dly, w_dly, r_dly, b_dly;
   int           ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
   bit           p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
   logic [63:0]  p_araddr;
   int           aw_cyc, w_cyc, rv_pulses;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic int pick(input int d);
      return rnd_dly ? int'($urandom_range(0, 3)) : d;
   endfunction

   function automatic logic [63:0] model_rdata(input logic [63:0] a);
      return ovr_en ? ovr_data : {a[31:0] ^ 32'h1357_9BDF, ~a[31:0]};
   endfunction

   function automatic bit model_err(input logic [63:0] a);
      return a[3];
   endfunction

   task automatic clear_state();
      axi_resp = '0;
      sb.delete();
      p_req = '0; p_we = '0;
      m_ptr = N - 1; busy = 0;
      rd_pend = 0; aw_got = 0; w_got = 0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
      p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
   endtask

   task automatic monitor();
      exp_t e;
      if (p_arv && !p_arr) begin
         check("ar_valid_hold", axi_req.ar_valid, 1);
         check("ar_addr_stable", axi_req.ar.addr, p_araddr);
      end
      if (p_awv && !p_awr) check("aw_valid_hold", axi_req.aw_valid, 1);
      if (p_wv && !p_wr)   check("w_valid_hold", axi_req.w_valid, 1);
      if (axi_req.b_ready) check("b_ready_vs_aw_w", axi_req.aw_valid | axi_req.w_valid, 0);
      if (axi_req.aw_valid) aw_cyc++;
      if (axi_req.w_valid)  w_cyc++;
      if (rvalid != '0) begin
         rv_pulses++;
         if (sb.size() == 0) check("rvalid_unexpected", rvalid, 0);
         else begin
            e = sb.pop_front();
            check("rvalid_onehot", rvalid, 64'(1) << e.win);
            if (!e.we) check("rdata", rdata, e.data);
            check("err", err, e.err);
         end
         busy = 0;
      end
   endtask

   task automatic slave();
      exp_t e;
      if (axi_req.ar_valid) begin
         if (ar_cnt == 0) begin
            axi_resp.ar_ready = 1'b1;
            if (sb.size() == 0) check("ar_sb_size", sb.size(), 1);
            else begin
               e = sb[0];
               check("ar_id", axi_req.ar.id, e.win);
               check("ar_addr", axi_req.ar.addr, e.addr);
               check("ar_fields", {axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst, axi_req.ar.cache,
                                   axi_req.ar.lock, axi_req.ar.prot, axi_req.ar.qos, axi_req.ar.region},
                     {8'd0, 3'd3, 2'b01, 4'b0010, 1'b0, 3'd0, 4'd0, 4'd0});
            end
            rd_pend = 1; r_cnt = pick(r_dly);
            rd_data = model_rdata(axi_req.ar.addr);
            rd_err  = model_err(axi_req.ar.addr);
         end else begin
            axi_resp.ar_ready = 1'b0; ar_cnt--;
         end
      end else begin
         axi_resp.ar_ready = 1'b0; ar_cnt = pick(ar_dly);
      end

      axi_resp.r.data = {$urandom, $urandom};
      axi_resp.r.id   = 4'($urandom);
      if (rd_pend && axi_req.r_ready && r_cnt == 0) begin
         axi_resp.r_valid = 1'b1;
         axi_resp.r.data  = rd_data;
         axi_resp.r.resp  = {rd_err, 1'b0};
         axi_resp.r.last  = rnd_dly ? 1'($urandom_range(0, 1)) : 1'b1;
         rd_pend = 0;
      end else begin
         axi_resp.r_valid = 1'b0;
         if (rd_pend && axi_req.r_ready) r_cnt--;
      end

      if (axi_req.aw_valid) begin
         if (aw_cnt == 0) begin
            axi_resp.aw_ready = 1'b1;
            aw_got = 1; b_cnt = pick(b_dly);
            wr_err = model_err(axi_req.aw.addr);
            if (sb.size() == 0) check("aw_sb_size", sb.size(), 1);
            else begin
               e = sb[0];
               check("aw_id", axi_req.aw.id, e.win);
               check("aw_addr", axi_req.aw.addr, e.addr);
               check("aw_fields", {axi_req.aw.len, axi_req.aw.size, axi_req.aw.burst, axi_req.aw.cache,
                                   axi_req.aw.lock, axi_req.aw.prot, axi_req.aw.atop},
                     {8'd0, 3'd3, 2'b01, 4'b0010, 1'b0, 3'd0, 6'd0});
            end
         end else begin
            axi_resp.aw_ready = 1'b0; aw_cnt--;
         end
      end else begin
         axi_resp.aw_ready = 1'b0; aw_cnt = pick(aw_dly);
      end

      if (axi_req.w_valid) begin
         if (w_cnt == 0) begin
            axi_resp.w_ready = 1'b1;
            w_got = 1;
            if (sb.size() != 0) begin
               e = sb[0];
               check("w_data", axi_req.w.data, e.data);
               check("w_strb_last", {axi_req.w.strb, axi_req.w.last}, {e.be, 1'b1});
            end
         end else begin
            axi_resp.w_ready = 1'b0; w_cnt--;
         end
      end else begin
         axi_resp.w_ready = 1'b0; w_cnt = pick(w_dly);
      end

      axi_resp.b.id = 4'($urandom);
      if (aw_got && w_got && axi_req.b_ready && b_cnt == 0) begin
         axi_resp.b_valid = 1'b1;
         axi_resp.b.resp  = {wr_err, 1'b0};
         aw_got = 0; w_got = 0;
      end else begin
         axi_resp.b_valid = 1'b0;
         if (aw_got && w_got && axi_req.b_ready) b_cnt--;
      end

      p_arv = axi_req.ar_valid; p_arr = axi_resp.ar_ready; p_araddr = axi_req.ar.addr;
      p_awv = axi_req.aw_valid; p_awr = axi_resp.aw_ready;
      p_wv  = axi_req.w_valid;  p_wr  = axi_resp.w_ready;
   endtask

   task automatic gnt_check();
      logic [N-1:0] exp_g;
      exp_t         e;
      int           w, c;
      exp_g = '0; w = -1;
      if (!busy && rvalid == '0) begin
         for (int i = 1; i <= N; i++) begin
            c = (m_ptr + i) % N;
            if (w < 0 && p_req[c]) w = c;
         end
      end
      if (w >= 0) exp_g[w] = 1'b1;
      if (gnt != '0 || exp_g != '0) check("gnt", gnt, exp_g);
      if (w >= 0) begin
         e.win = w; e.we = p_we[w]; e.addr = p_addr[w]; e.be = p_be[w];
         e.data = p_we[w] ? p_wdata[w] : model_rdata(p_addr[w]);
         e.err  = model_err(p_addr[w]);
         sb.push_back(e);
         m_ptr = w; busy = 1; p_req[w] = 1'b0; last_win = w; n_grants++;
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      slave();
      if (rand_on) begin
         for (int k = 0; k < N; k++) begin
            if (!p_req[k] && $urandom_range(0, 2) == 0) begin
               p_req[k] = 1'b1; p_we[k] = 1'($urandom);
               p_addr[k] = {$urandom, $urandom}; p_wdata[k] = {$urandom, $urandom};
               p_be[k] = 8'($urandom);
            end
         end
      end
      req = p_req; we = p_we;
      for (int k = 0; k < N; k++) begin
         addr[k] = p_addr[k]; wdata[k] = p_wdata[k]; be[k] = p_be[k];
      end
      #1 gnt_check();
   endtask

   task automatic run_one(input logic [3:0] rq, input logic [3:0] wq, input logic [63:0] base);
      int g0;
      p_req = rq; p_we = wq;
      for (int k = 0; k < N; k++) begin
         p_addr[k] = base + 64'(k * 256); p_wdata[k] = {$urandom, $urandom}; p_be[k] = 8'($urandom);
      end
      last_win = -1; g0 = n_grants;
      for (int t = 0; t < 50 && n_grants == g0; t++) step();
      p_req = '0;
      for (int t = 0; t < 60 && (busy || sb.size() != 0); t++) step();
      check("txn_drained", sb.size(), 0);
   endtask

   vec_t vecs[16];

   initial begin
      rnd_dly = 0; ovr_en = 0; ovr_data = '0; rand_on = 0; n_grants = 0;
      ar_dly = 0; aw_dly = 0; w_dly = 0; r_dly = 1; b_dly = 1;
      aw_cyc = 0; w_cyc = 0; rv_pulses = 0; last_win = -1;
      for (int k = 0; k < N; k++) begin p_addr[k] = '0; p_wdata[k] = '0; p_be[k] = '0; end
      clear_state();
      rst_n = 1'b0; req = '1; we = '0; addr = '0; wdata = '0; be = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_gnt", gnt, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata_err", {rdata, err}, 0);
      check("rst_axi_valids", {axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid,
                               axi_req.r_ready, axi_req.b_ready}, 0);
      req = '0;
      @(negedge clk) rst_n = 1'b1;

      // {req, we, expected winner, address base}; pointer starts at N-1
      vecs[0]  = '{4'b0001, 4'b0000, 0, 64'h80};
      for (int i = 1; i <= 8; i++) vecs[i] = '{4'b1111, 4'b0000, i % 4, 64'h4000_0000 + 64'(i) * 64'h1000};
      vecs[9]  = '{4'b0100, 4'b0100, 2, 64'h4001_0000};
      vecs[10] = '{4'b0100, 4'b0000, 2, 64'h4002_0000};
      vecs[11] = '{4'b1001, 4'b1001, 3, 64'h4003_0008};
      vecs[12] = '{4'b1001, 4'b0000, 0, 64'h4004_0000};
      vecs[13] = '{4'b0110, 4'b0010, 1, 64'h4005_0000};
      vecs[14] = '{4'b0010, 4'b0010, 1, 64'h4006_0008};
      vecs[15] = '{4'b0010, 4'b0000, 1, 64'h4007_0000};
      for (int r = 0; r < 16; r++) begin
         ovr_en = (r == 0); ovr_data = 64'hDEAD;
         run_one(vecs[r].req, vecs[r].we, vecs[r].base);
         check("tbl_winner", 64'(last_win), 64'(vecs[r].exp_win));
         if (r == 0) check("first_read_data", rdata, 64'hDEAD);
         if (r == 14 || r == 15) check("err_after_txn", err, (r == 14) ? 1 : 0);
      end
      ovr_en = 0;

      // write with delayed AW, immediate W
      aw_dly = 3; w_dly = 0; aw_cyc = 0; w_cyc = 0; rv_pulses = 0;
      run_one(4'b1000, 4'b1000, 64'h5000_0000);
      check("aw_valid_cycles", aw_cyc, 4);
      check("w_valid_cycles", w_cyc, 1);
      check("write_rvalid_pulses", rv_pulses, 1);
      aw_dly = 0;

      // reset while in R with r_valid pending
      r_dly = 6; p_req = 4'b0010; p_we = '0; p_addr[1] = 64'h6000_0000;
      for (int t = 0; t < 30 && !(rd_pend && axi_req.r_ready); t++) step();
      check("reached_r_state", axi_req.r_ready, 1);
      @(negedge clk) rst_n = 1'b0;
      #1;
      check("async_rst_gnt_rvalid", {gnt, rvalid}, 0);
      check("async_rst_rdata_err", {rdata, err}, 0);
      check("async_rst_axi", {axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid,
                              axi_req.r_ready, axi_req.b_ready}, 0);
      clear_state();
      repeat (2) @(negedge clk);
      rst_n = 1'b1; r_dly = 1;
      run_one(4'b0100, 4'b0000, 64'h7000_0000);
      check("post_rst_winner", 64'(last_win), 2);

      // random requests and random ready stalls
      begin
         int g0, r0;
         rnd_dly = 1; rand_on = 1; g0 = n_grants; rv_pulses = 0;
         for (int t = 0; t < 60000 && n_grants - g0 < 2500; t++) step();
         rand_on = 0; p_req = '0;
         for (int t = 0; t < 60 && (busy || sb.size() != 0); t++) step();
         r0 = n_grants - g0;
         check("rand_grants", r0, 2500);
         check("rand_one_rvalid_per_gnt", rv_pulses, r0);
         check("rand_drained", sb.size(), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
